// File: rtl/sort_stream_ctrl.sv
// Streaming sort controller: loads one packet into an external RAM, hands the
// RAM to an external sorter, then streams the sorted words back out through a
// 2-entry output buffer with valid/ready flow control.
module sort_stream_ctrl #(
   parameter int DWIDTH  = 10,
   parameter int ADDR_SZ = 10
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic [DWIDTH-1:0]  snk_data_i,
   input  logic               snk_startofpacket_i,
   input  logic               snk_endofpacket_i,
   input  logic               snk_valid_i,
   output logic               snk_ready_o,
   output logic [DWIDTH-1:0]  src_data_o,
   output logic               src_startofpacket_o,
   output logic               src_endofpacket_o,
   output logic               src_valid_o,
   input  logic               src_ready_i,
   output logic [ADDR_SZ-1:0] ram_address_o,
   output logic [DWIDTH-1:0]  ram_data_o,
   output logic               ram_wren_o,
   input  logic [DWIDTH-1:0]  ram_q_i,
   output logic               sorting_o,
   output logic [ADDR_SZ-1:0] max_counter_o,
   input  logic               done_i
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      DROP   = 3'd2,
      SORT   = 3'd3,
      UNLOAD = 3'd4
   } state_t;

   // Counts carry one extra bit so a full 2**ADDR_SZ packet does not wrap.
   localparam logic [ADDR_SZ:0] CNT_ZERO  = {(ADDR_SZ+1){1'b0}};
   localparam logic [ADDR_SZ:0] CNT_ONE   = {{ADDR_SZ{1'b0}}, 1'b1};
   localparam logic [ADDR_SZ:0] LAST_ADDR = {1'b0, {ADDR_SZ{1'b1}}};

   state_t              state_q;
   logic [ADDR_SZ:0]    count_q;
   logic [ADDR_SZ:0]    n_q;
   logic [ADDR_SZ-1:0]  max_counter_q;
   logic                sorting_q;
   logic                snk_ready_q;
   logic [ADDR_SZ:0]    rd_addr_q;
   logic                rd_pend_q;
   logic                pend_sop_q;
   logic                pend_eop_q;
   logic [1:0]          buf_cnt_q;
   logic [DWIDTH-1:0]   b0_data_q;
   logic                b0_sop_q;
   logic                b0_eop_q;
   logic [DWIDTH-1:0]   b1_data_q;
   logic                b1_sop_q;
   logic                b1_eop_q;

   logic                accept_s;
   logic                wr_en_s;
   logic [ADDR_SZ:0]    wr_addr_s;
   logic [ADDR_SZ:0]    count_d;
   logic                eol_s;
   logic                to_drop_s;
   logic [ADDR_SZ:0]    eol_count_s;
   logic                pop_s;
   logic [2:0]          occ_s;
   logic                issue_s;

   // Load-side decode: write strobe, write address, next count, end-of-load.
   always_comb begin
      accept_s    = snk_valid_i & snk_ready_q;
      wr_en_s     = 1'b0;
      wr_addr_s   = CNT_ZERO;
      count_d     = count_q;
      eol_s       = 1'b0;
      to_drop_s   = 1'b0;
      eol_count_s = count_q;
      case (state_q)
         IDLE: begin
            if (accept_s && snk_startofpacket_i) begin
               wr_en_s     = 1'b1;
               count_d     = CNT_ONE;
               eol_s       = snk_endofpacket_i;
               eol_count_s = CNT_ONE;
            end else begin
               wr_en_s = 1'b0;
            end
         end
         LOAD: begin
            if (accept_s) begin
               wr_en_s = 1'b1;
               if (snk_startofpacket_i) begin
                  wr_addr_s = CNT_ZERO;
                  count_d   = CNT_ONE;
               end else begin
                  wr_addr_s = count_q;
                  count_d   = count_q + CNT_ONE;
               end
               eol_s       = snk_endofpacket_i;
               to_drop_s   = !snk_endofpacket_i && !snk_startofpacket_i &&
                             (count_q == LAST_ADDR);
               eol_count_s = count_d;
            end else begin
               wr_en_s = 1'b0;
            end
         end
         DROP: begin
            if (accept_s) begin
               eol_s = snk_endofpacket_i;
            end else begin
               eol_s = 1'b0;
            end
         end
         default: begin
            wr_en_s = 1'b0;
         end
      endcase
   end

   // Unload-side decode: issue a read only if the buffer can absorb it.
   always_comb begin
      pop_s   = (buf_cnt_q != 2'd0) && src_ready_i;
      occ_s   = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q};
      issue_s = (state_q == UNLOAD) && (rd_addr_q < n_q) &&
                ((occ_s - {2'b00, pop_s}) < 3'd2);
   end

   // Controller state, counters, read pipeline and output buffer.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= IDLE;
         count_q       <= CNT_ZERO;
         n_q           <= CNT_ZERO;
         max_counter_q <= {ADDR_SZ{1'b0}};
         sorting_q     <= 1'b0;
         snk_ready_q   <= 1'b0;
         rd_addr_q     <= CNT_ZERO;
         rd_pend_q     <= 1'b0;
         pend_sop_q    <= 1'b0;
         pend_eop_q    <= 1'b0;
         buf_cnt_q     <= 2'd0;
         b0_data_q     <= {DWIDTH{1'b0}};
         b0_sop_q      <= 1'b0;
         b0_eop_q      <= 1'b0;
         b1_data_q     <= {DWIDTH{1'b0}};
         b1_sop_q      <= 1'b0;
         b1_eop_q      <= 1'b0;
      end else begin
         // read pipeline: data returns one cycle after the address
         rd_pend_q <= issue_s;
         if (issue_s) begin
            pend_sop_q <= (rd_addr_q == CNT_ZERO);
            pend_eop_q <= (rd_addr_q == (n_q - CNT_ONE));
            rd_addr_q  <= rd_addr_q + CNT_ONE;
         end

         // two-entry buffer, entry 0 is the head presented on src_*
         case ({rd_pend_q, pop_s})
            2'b10: begin
               if (buf_cnt_q == 2'd0) begin
                  b0_data_q <= ram_q_i;
                  b0_sop_q  <= pend_sop_q;
                  b0_eop_q  <= pend_eop_q;
               end else begin
                  b1_data_q <= ram_q_i;
                  b1_sop_q  <= pend_sop_q;
                  b1_eop_q  <= pend_eop_q;
               end
               buf_cnt_q <= buf_cnt_q + 2'd1;
            end
            2'b01: begin
               b0_data_q <= b1_data_q;
               b0_sop_q  <= b1_sop_q;
               b0_eop_q  <= b1_eop_q;
               buf_cnt_q <= buf_cnt_q - 2'd1;
            end
            2'b11: begin
               if (buf_cnt_q == 2'd1) begin
                  b0_data_q <= ram_q_i;
                  b0_sop_q  <= pend_sop_q;
                  b0_eop_q  <= pend_eop_q;
               end else begin
                  b0_data_q <= b1_data_q;
                  b0_sop_q  <= b1_sop_q;
                  b0_eop_q  <= b1_eop_q;
                  b1_data_q <= ram_q_i;
                  b1_sop_q  <= pend_sop_q;
                  b1_eop_q  <= pend_eop_q;
               end
            end
            default: begin
               buf_cnt_q <= buf_cnt_q;
            end
         endcase

         case (state_q)
            IDLE, LOAD: begin
               snk_ready_q <= 1'b1;
               if (wr_en_s) begin
                  count_q <= count_d;
                  if (to_drop_s) begin
                     state_q <= DROP;
                  end else begin
                     state_q <= LOAD;
                  end
               end else begin
                  state_q <= state_q;
               end
            end
            DROP: begin
               snk_ready_q <= 1'b1;
            end
            SORT: begin
               snk_ready_q <= 1'b0;
               if (done_i) begin
                  sorting_q <= 1'b0;
                  state_q   <= UNLOAD;
               end else begin
                  sorting_q <= 1'b1;
               end
            end
            UNLOAD: begin
               if (pop_s && b0_eop_q) begin
                  state_q     <= IDLE;
                  snk_ready_q <= 1'b1;
               end else begin
                  snk_ready_q <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               sorting_q   <= 1'b0;
               snk_ready_q <= 1'b1;
            end
         endcase

         // end of load overrides the per-state updates above
         if (eol_s) begin
            max_counter_q <= eol_count_s[ADDR_SZ-1:0];
            n_q           <= eol_count_s;
            rd_addr_q     <= CNT_ZERO;
            snk_ready_q   <= 1'b0;
            if (eol_count_s == CNT_ONE) begin
               state_q   <= UNLOAD;
               sorting_q <= 1'b0;
            end else begin
               state_q   <= SORT;
               sorting_q <= 1'b1;
            end
         end
      end
   end

   assign snk_ready_o         = snk_ready_q;
   assign sorting_o           = sorting_q;
   assign max_counter_o       = max_counter_q;
   assign ram_wren_o          = wr_en_s;
   assign ram_data_o          = wr_en_s ? snk_data_i : {DWIDTH{1'b0}};
   assign ram_address_o       = (state_q == UNLOAD) ? rd_addr_q[ADDR_SZ-1:0]
                                                    : wr_addr_s[ADDR_SZ-1:0];
   assign src_valid_o         = (buf_cnt_q != 2'd0);
   assign src_data_o          = b0_data_q;
   assign src_startofpacket_o = (buf_cnt_q != 2'd0) && b0_sop_q;
   assign src_endofpacket_o   = (buf_cnt_q != 2'd0) && b0_eop_q;

endmodule
